// File: rtl/csr_wb_unit.sv
// Machine-mode CSR file committing WB-stage CSR writes/mret, serving the EX read port with
// bypass, taking timer/external interrupts and sleeping on WFI. Counters guarded by CSR_COUNTER_EN.
module csr_wb_unit #(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        csr_we_i,
  input  logic        csr_ret_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [31:0] csr_wdata_i,
  input  logic        retire_i,
  input  logic [11:0] csr_raddr_i,
  output logic [31:0] csr_rdata_o,
  input  logic [31:0] pc_i,
  input  logic        wfi_i,
  input  logic        timer_irq_i,
  input  logic        ext_irq_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        sleep_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;
  localparam logic [11:0] A_MINSTR   = 12'hB02;
  localparam logic [11:0] A_MINSTRH  = 12'hB82;
  localparam logic [11:0] A_CYCLE    = 12'hC00;
  localparam logic [11:0] A_CYCLEH   = 12'hC80;
  localparam logic [11:0] A_INSTRET  = 12'hC02;
  localparam logic [11:0] A_INSTRETH = 12'hC82;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e      state_r;
  logic        sleep_r;
  logic        trap_r;
  logic        mst_mie_r;
  logic        mst_mpie_r;
  logic        mtie_r;
  logic        meie_r;
  logic [29:0] mtvec_r;
  logic [29:0] mepc_r;
  logic [31:0] mcause_r;

  logic        wr_s;
  logic        ret_s;
  logic        ext_s;
  logic        pend_s;
  logic        take_s;
  logic [31:0] mstatus_s;
  logic [31:0] mie_s;
  logic [31:0] mip_s;
  logic [31:0] rd_s;
  logic [1:0]  unused_pc_s;

  assign wr_s        = csr_we_i & ~stall;
  assign ret_s       = csr_ret_i & ~stall;
  assign ext_s       = ext_irq_i & meie_r;
  assign pend_s      = ext_s | (timer_irq_i & mtie_r);
  assign take_s      = pend_s & mst_mie_r & (state_r == ST_RUN) & ~csr_ret_i;
  assign unused_pc_s = pc_i[1:0];

  assign mstatus_s = {19'd0, 2'b11, 3'd0, mst_mpie_r, 3'd0, mst_mie_r, 3'd0};
  assign mie_s     = {20'd0, meie_r, 3'd0, mtie_r, 7'd0};
  assign mip_s     = {20'd0, ext_irq_i, 3'd0, timer_irq_i, 7'd0};

  // Commit of WB writes, then mret, then trap entry; later assignments take precedence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie_r  <= 1'b0;
      mst_mpie_r <= 1'b0;
      mtie_r     <= 1'b0;
      meie_r     <= 1'b0;
      mtvec_r    <= MTVEC_RST[31:2];
      mepc_r     <= 30'd0;
      mcause_r   <= 32'd0;
    end else begin
      if (wr_s) begin
        case (csr_waddr_i)
          A_MSTATUS: begin
            mst_mie_r  <= csr_wdata_i[3];
            mst_mpie_r <= csr_wdata_i[7];
          end
          A_MIE: begin
            mtie_r <= csr_wdata_i[7];
            meie_r <= csr_wdata_i[11];
          end
          A_MTVEC:  mtvec_r  <= csr_wdata_i[31:2];
          A_MEPC:   mepc_r   <= csr_wdata_i[31:2];
          A_MCAUSE: mcause_r <= csr_wdata_i;
          default: ;
        endcase
      end
      if (ret_s) begin
        mst_mie_r  <= mst_mpie_r;
        mst_mpie_r <= 1'b1;
      end
      if (take_s) begin
        mepc_r     <= pc_i[31:2];
        mcause_r   <= ext_s ? {1'b1, 27'd0, 4'd11} : {1'b1, 27'd0, 4'd7};
        mst_mpie_r <= mst_mie_r;
        mst_mie_r  <= 1'b0;
      end
    end
  end

  // Run/sleep/trap sequencing with the trap redirect and sleep flags registered alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      sleep_r <= 1'b0;
      trap_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (take_s) begin
            state_r <= ST_TRAP;
            trap_r  <= 1'b1;
            sleep_r <= 1'b0;
          end else if (wfi_i && !stall && !pend_s) begin
            state_r <= ST_SLEEP;
            trap_r  <= 1'b0;
            sleep_r <= 1'b1;
          end else begin
            state_r <= ST_RUN;
            trap_r  <= 1'b0;
            sleep_r <= 1'b0;
          end
        end
        ST_SLEEP: begin
          trap_r <= 1'b0;
          if (pend_s) begin
            state_r <= ST_RUN;
            sleep_r <= 1'b0;
          end else begin
            state_r <= ST_SLEEP;
            sleep_r <= 1'b1;
          end
        end
        ST_TRAP: begin
          state_r <= ST_RUN;
          trap_r  <= 1'b0;
          sleep_r <= 1'b0;
        end
        default: begin
          state_r <= ST_RUN;
          trap_r  <= 1'b0;
          sleep_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef CSR_COUNTER_EN
  logic [63:0] mcycle_r;
  logic [63:0] minstret_r;

  // 64-bit counters; a write to either half replaces that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle_r   <= 64'd0;
      minstret_r <= 64'd0;
    end else begin
      if (wr_s && (csr_waddr_i == A_MCYCLE)) begin
        mcycle_r[31:0] <= csr_wdata_i;
      end else if (wr_s && (csr_waddr_i == A_MCYCLEH)) begin
        mcycle_r[63:32] <= csr_wdata_i;
      end else begin
        mcycle_r <= mcycle_r + 64'd1;
      end
      if (wr_s && (csr_waddr_i == A_MINSTR)) begin
        minstret_r[31:0] <= csr_wdata_i;
      end else if (wr_s && (csr_waddr_i == A_MINSTRH)) begin
        minstret_r[63:32] <= csr_wdata_i;
      end else if (retire_i && !stall) begin
        minstret_r <= minstret_r + 64'd1;
      end else begin
        minstret_r <= minstret_r;
      end
    end
  end
`else
  logic unused_retire_s;
  assign unused_retire_s = retire_i;
`endif

  // Architectural read mux; unimplemented addresses read zero.
  always_comb begin
    rd_s = 32'd0;
    case (csr_raddr_i)
      A_MSTATUS: rd_s = mstatus_s;
      A_MIE:     rd_s = mie_s;
      A_MTVEC:   rd_s = {mtvec_r, 2'b00};
      A_MEPC:    rd_s = {mepc_r, 2'b00};
      A_MCAUSE:  rd_s = mcause_r;
      A_MIP:     rd_s = mip_s;
      A_MHARTID: rd_s = HART_ID;
`ifdef CSR_COUNTER_EN
      A_MCYCLE, A_CYCLE:     rd_s = mcycle_r[31:0];
      A_MCYCLEH, A_CYCLEH:   rd_s = mcycle_r[63:32];
      A_MINSTR, A_INSTRET:   rd_s = minstret_r[31:0];
      A_MINSTRH, A_INSTRETH: rd_s = minstret_r[63:32];
`endif
      default:   rd_s = 32'd0;
    endcase
  end

  // EX read port: a committing WB write to the same address is forwarded.
  always_comb begin
    csr_rdata_o = rd_s;
    if (wr_s && (csr_waddr_i == csr_raddr_i)) begin
      if ((csr_raddr_i == A_MTVEC) || (csr_raddr_i == A_MEPC)) begin
        csr_rdata_o = {csr_wdata_i[31:2], 2'b00};
      end else begin
        csr_rdata_o = csr_wdata_i;
      end
    end else begin
      csr_rdata_o = rd_s;
    end
  end

  // mret redirects in its commit cycle; trap redirect follows one cycle after the take.
  always_comb begin
    redirect_pc_o = 32'd0;
    if (ret_s) begin
      redirect_pc_o = {mepc_r, 2'b00};
    end else if (trap_r) begin
      redirect_pc_o = {mtvec_r, 2'b00};
    end else begin
      redirect_pc_o = 32'd0;
    end
  end

  assign redirect_o = trap_r | ret_s;
  assign sleep_o    = sleep_r;

endmodule

// File: tb/tb_csr_wb_unit.sv
// Self-checking bench for csr_wb_unit: directed scenarios plus randomized traffic
// compared against a behavioural CSR/interrupt model.
module tb_csr_wb_unit;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1003;
  localparam logic [31:0] HART_ID   = 32'h0000_0005;

  logic        clk, rst_n, stall, csr_we_i, csr_ret_i, retire_i, wfi_i;
  logic        timer_irq_i, ext_irq_i, redirect_o, sleep_o;
  logic [11:0] csr_waddr_i, csr_raddr_i;
  logic [31:0] csr_wdata_i, csr_rdata_o, pc_i, redirect_pc_o;

  int n_assert = 0;
  int n_fail   = 0;

  csr_wb_unit #(.MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .csr_we_i(csr_we_i), .csr_ret_i(csr_ret_i),
    .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i), .retire_i(retire_i),
    .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .pc_i(pc_i), .wfi_i(wfi_i),
    .timer_irq_i(timer_irq_i), .ext_irq_i(ext_irq_i), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .sleep_o(sleep_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode 0 = running, 1 = asleep, 2 = trap redirect pending
  bit          m_mie, m_mpie, m_mtie, m_meie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  int          m_mode;
  logic [63:0] m_cyc, m_ret;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mie = 0; m_mpie = 0; m_mtie = 0; m_meie = 0;
    m_mtvec = MTVEC_RST & 32'hFFFF_FFFC;
    m_mepc = 32'd0; m_mcause = 32'd0; m_mode = 0;
    m_cyc = 64'd0; m_ret = 64'd0;
  endtask

  function automatic logic [31:0] model_csr(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 + (m_mie ? 32'd8 : 32'd0) + (m_mpie ? 32'd128 : 32'd0);
      12'h304: return (m_mtie ? 32'd128 : 32'd0) + (m_meie ? 32'd2048 : 32'd0);
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return (timer_irq_i ? 32'd128 : 32'd0) + (ext_irq_i ? 32'd2048 : 32'd0);
      12'hF14: return HART_ID;
`ifdef CSR_COUNTER_EN
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ret[31:0];
      12'hB82, 12'hC82: return m_ret[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_update();
    bit we, rt, ext_en, pend, take, o_mie, o_mpie;
    int nxt;
    we = csr_we_i && !stall;
    rt = csr_ret_i && !stall;
    o_mie = m_mie; o_mpie = m_mpie;
    ext_en = ext_irq_i && m_meie;
    pend = ext_en || (timer_irq_i && m_mtie);
    take = pend && o_mie && (m_mode == 0) && !csr_ret_i;
    if (we && csr_waddr_i == 12'hB00) m_cyc[31:0] = csr_wdata_i;
    else if (we && csr_waddr_i == 12'hB80) m_cyc[63:32] = csr_wdata_i;
    else m_cyc = m_cyc + 64'd1;
    if (we && csr_waddr_i == 12'hB02) m_ret[31:0] = csr_wdata_i;
    else if (we && csr_waddr_i == 12'hB82) m_ret[63:32] = csr_wdata_i;
    else if (retire_i && !stall) m_ret = m_ret + 64'd1;
    if (we) begin
      case (csr_waddr_i)
        12'h300: begin m_mie = csr_wdata_i[3]; m_mpie = csr_wdata_i[7]; end
        12'h304: begin m_mtie = csr_wdata_i[7]; m_meie = csr_wdata_i[11]; end
        12'h305: m_mtvec = csr_wdata_i & 32'hFFFF_FFFC;
        12'h341: m_mepc = csr_wdata_i & 32'hFFFF_FFFC;
        12'h342: m_mcause = csr_wdata_i;
        default: ;
      endcase
    end
    if (rt) begin m_mie = o_mpie; m_mpie = 1; end
    if (take) begin
      m_mepc = pc_i & 32'hFFFF_FFFC;
      m_mcause = ext_en ? 32'h8000_000B : 32'h8000_0007;
      m_mpie = o_mie; m_mie = 0;
    end
    nxt = m_mode;
    if (m_mode == 0) begin
      if (take) nxt = 2;
      else if (wfi_i && !stall && !pend) nxt = 1;
    end else if (m_mode == 1) begin
      if (pend) nxt = 0;
    end else begin
      nxt = 0;
    end
    m_mode = nxt;
  endtask

  task automatic idle();
    stall = 0; csr_we_i = 0; csr_ret_i = 0; retire_i = 0; wfi_i = 0;
    timer_irq_i = 0; ext_irq_i = 0; csr_waddr_i = 12'h000; csr_raddr_i = 12'h000;
    csr_wdata_i = 32'd0; pc_i = 32'd0;
  endtask

  // Called at a negedge with inputs driven: check outputs, clock once, advance model.
  task automatic step(input string tag);
    logic [31:0] e_rd, e_pc;
    bit wr, rt, e_redir, e_sleep;
    wr = csr_we_i && !stall;
    rt = csr_ret_i && !stall;
    if (wr && csr_waddr_i == csr_raddr_i)
      e_rd = (csr_raddr_i == 12'h305 || csr_raddr_i == 12'h341) ? (csr_wdata_i & 32'hFFFF_FFFC) : csr_wdata_i;
    else
      e_rd = model_csr(csr_raddr_i);
    e_redir = (m_mode == 2) || rt;
    e_pc = rt ? m_mepc : ((m_mode == 2) ? m_mtvec : 32'd0);
    e_sleep = (m_mode == 1);
    #1;
    chk({tag, ".rdata"}, csr_rdata_o, e_rd);
    chk({tag, ".redirect"}, {31'd0, redirect_o}, {31'd0, e_redir});
    chk({tag, ".redirect_pc"}, redirect_pc_o, e_pc);
    chk({tag, ".sleep"}, {31'd0, sleep_o}, {31'd0, e_sleep});
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic wr_csr(input string tag, input logic [11:0] a, input logic [31:0] d);
    csr_we_i = 1; csr_waddr_i = a; csr_wdata_i = d;
    step(tag);
    csr_we_i = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [11:0] addrs [13];
  logic [63:0] saved;

  initial begin
    addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'hF14,
              12'hB00, 12'hB80, 12'hB02, 12'hC00, 12'hC82, 12'h123};
    idle();
    rst_n = 1;
    #1 rst_n = 0;
    model_reset();
    #2;
    chk("reset.redirect", {31'd0, redirect_o}, 32'd0);
    chk("reset.sleep", {31'd0, sleep_o}, 32'd0);
    chk("reset.redirect_pc", redirect_pc_o, 32'd0);
    csr_raddr_i = 12'h305; #1 chk("reset.mtvec", csr_rdata_o, 32'h0000_1000);
    csr_raddr_i = 12'h300; #1 chk("reset.mstatus", csr_rdata_o, 32'h0000_1800);
    csr_raddr_i = 12'hF14; #1 chk("reset.mhartid", csr_rdata_o, 32'h0000_0005);
    @(negedge clk);
    rst_n = 1;

    // Write with same-cycle bypass, then a stalled write that must be dropped
    csr_we_i = 1; csr_waddr_i = 12'h305; csr_wdata_i = 32'h8000_0103; csr_raddr_i = 12'h305;
    #1 chk("t2.bypass", csr_rdata_o, 32'h8000_0100);
    step("t2.wr");
    stall = 1; csr_wdata_i = 32'h0000_0444;
    #1 chk("t2.stall_nobypass", csr_rdata_o, 32'h8000_0100);
    step("t2.stall");
    stall = 0; csr_we_i = 0;
    #1 chk("t2.kept", csr_rdata_o, 32'h8000_0100);
    step("t2.read");
    csr_raddr_i = 12'h341;
    wr_csr("t2.mepc", 12'h341, 32'h0000_0ABF);

    // Timer trap
    wr_csr("t3.mstatus", 12'h300, 32'h0000_0008);
    wr_csr("t3.mie", 12'h304, 32'h0000_0080);
    timer_irq_i = 1; pc_i = 32'h0000_0200;
    step("t3.take");
    #1 chk("t3.redirect", {31'd0, redirect_o}, 32'd1);
    chk("t3.redirect_pc", redirect_pc_o, 32'h8000_0100);
    chk("t3.mepc", csr_rdata_o, 32'h0000_0200);
    step("t3.trap");
    csr_raddr_i = 12'h342; #1 chk("t3.mcause", csr_rdata_o, 32'h8000_0007);
    step("t3.mcause_rd");
    timer_irq_i = 0;
    csr_raddr_i = 12'h300; #1 chk("t3.mstatus", csr_rdata_o, 32'h0000_1880);
    step("t3.mstatus_rd");

    // mret colliding with a pending external interrupt
    wr_csr("t4.mie", 12'h304, 32'h0000_0880);
    ext_irq_i = 1;
    step("t4.pend");
    csr_ret_i = 1; pc_i = 32'h0000_0300;
    #1 chk("t4.mret_redirect", {31'd0, redirect_o}, 32'd1);
    chk("t4.mret_pc", redirect_pc_o, 32'h0000_0200);
    step("t4.mret");
    csr_ret_i = 0;
    #1 chk("t4.no_redirect_yet", {31'd0, redirect_o}, 32'd0);
    step("t4.take");
    csr_raddr_i = 12'h342;
    #1 chk("t4.trap_pc", redirect_pc_o, 32'h8000_0100);
    chk("t4.mcause", csr_rdata_o, 32'h8000_000B);
    step("t4.trap");
    ext_irq_i = 0;
    csr_raddr_i = 12'h300;
    step("t4.after");

    // WFI sleep and wake without trap
    wfi_i = 1;
    step("t5.wfi");
    wfi_i = 0;
    #1 chk("t5.asleep", {31'd0, sleep_o}, 32'd1);
    step("t5.sleep1");
    step("t5.sleep2");
    ext_irq_i = 1;
    step("t5.wake");
    #1 chk("t5.awake", {31'd0, sleep_o}, 32'd0);
    chk("t5.no_redirect", {31'd0, redirect_o}, 32'd0);
    step("t5.run1");
    step("t5.run2");
    ext_irq_i = 0;

`ifdef CSR_COUNTER_EN
    wr_csr("t6.mcycle", 12'hB00, 32'hFFFF_FFFF);
    csr_raddr_i = 12'hB00;
    step("t6.lo_written");
    csr_raddr_i = 12'hB80; #1 chk("t6.mcycleh", csr_rdata_o, 32'd1);
    csr_raddr_i = 12'hC80; #1 chk("t6.cycleh", csr_rdata_o, 32'd1);
    csr_raddr_i = 12'hB00;
    step("t6.lo_wrapped");
    saved = m_ret;
    retire_i = 1; stall = 1;
    step("t6.retire_stall");
    retire_i = 0; stall = 0; csr_raddr_i = 12'hB02;
    #1 chk("t6.minstret_held", csr_rdata_o, saved[31:0]);
    retire_i = 1;
    step("t6.retire");
    retire_i = 0;
    #1 chk("t6.minstret_inc", csr_rdata_o, saved[31:0] + 32'd1);
    step("t6.read");
`else
    wr_csr("t6.nocnt", 12'hB00, 32'h0000_1234);
    csr_raddr_i = 12'hB00; #1 chk("t6.absent", csr_rdata_o, 32'd0);
    step("t6.read");
`endif

    // Asynchronous reset in the middle of a trap redirect
    wr_csr("t1.mstatus", 12'h300, 32'h0000_0008);
    timer_irq_i = 1; pc_i = 32'h0000_0400;
    step("t1.take");
    #1 chk("t1.pre_redirect", {31'd0, redirect_o}, 32'd1);
    #1 rst_n = 0;
    #1 chk("t1.redirect", {31'd0, redirect_o}, 32'd0);
    chk("t1.sleep", {31'd0, sleep_o}, 32'd0);
    timer_irq_i = 0; csr_raddr_i = 12'h305;
    #1 chk("t1.mtvec", csr_rdata_o, 32'h0000_1000);
    csr_raddr_i = 12'h300;
    #1 chk("t1.mstatus", csr_rdata_o, 32'h0000_1800);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Asynchronous reset while asleep
    wfi_i = 1;
    step("t1.wfi");
    wfi_i = 0;
    #1 chk("t1.pre_sleep", {31'd0, sleep_o}, 32'd1);
    #1 rst_n = 0;
    #1 chk("t1.sleep_drop", {31'd0, sleep_o}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom_range(0, 99) < 25);
      csr_we_i    = ($urandom_range(0, 99) < 35);
      csr_ret_i   = ($urandom_range(0, 99) < 8);
      wfi_i       = ($urandom_range(0, 99) < 10);
      retire_i    = ($urandom_range(0, 99) < 60);
      if ($urandom_range(0, 99) < 10) timer_irq_i = ~timer_irq_i;
      if ($urandom_range(0, 99) < 10) ext_irq_i = ~ext_irq_i;
      csr_waddr_i = addrs[$urandom_range(0, 12)];
      csr_raddr_i = ($urandom_range(0, 1) == 0) ? csr_waddr_i : addrs[$urandom_range(0, 12)];
      csr_wdata_i = $urandom;
      pc_i        = $urandom;
      step("rand");
    end
    idle();
    step("rand.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
